// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write sequencer: state encoding,
// the power-on init command bytes and tick-target helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        RST_EXIT,
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        E_HIGH,
        E_WAIT,
        READY
    } lcd_state_e;

    localparam logic [7:0] INIT_FUNC_SET  = 8'h38;
    localparam logic [7:0] INIT_DISP_ON   = 8'h0C;
    localparam logic [7:0] INIT_CLEAR     = 8'h01;
    localparam logic [7:0] INIT_ENTRY_MD  = 8'h06;
    localparam logic [7:0] CLEAR_CMD      = 8'h01;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_FUNC_SET;
            2'd1:    return INIT_DISP_ON;
            2'd2:    return INIT_CLEAR;
            default: return INIT_ENTRY_MD;
        endcase
    endfunction

    // A zero wait would never complete; the 8-bit counter also caps the target.
    function automatic logic [7:0] clamp_ticks(input int unsigned ticks);
        if (ticks == 0) begin
            return 8'd1;
        end else if (ticks > 255) begin
            return 8'd255;
        end else begin
            return ticks[7:0];
        end
    endfunction

endpackage

// File: rtl/lcd_tick_counter.sv
// Counts timer ticks since the last clear; done fires combinationally on the
// cycle the target-th tick is presented.
module lcd_tick_counter (
    input  logic       clock,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_tick,
    input  logic [7:0] i_target,
    output logic       o_done
);

    logic [7:0] r_count;
    logic [8:0] w_count_next;

    assign w_count_next = {1'b0, r_count} + 9'd1;
    assign o_done       = i_tick && !i_clear && (w_count_next >= {1'b0, i_target});

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_tick && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780-style write sequencer: power-up wait, four-command init, then
// client byte writes, each strobed on LCD_E with tick-timed hold and gap.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_TICKS = 200,
    parameter int unsigned CMD_TICKS     = 1,
    parameter int unsigned CLEAR_TICKS   = 20,
    parameter int unsigned E_TICKS       = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       TimerIndicator,
    output logic       EnableCount,
    output logic       DisableCount,
    input  logic       WrReq,
    input  logic       WrRS,
    input  logic [7:0] WrData,
    output logic       WrReady,
    output logic       InitDone,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA
);

    localparam logic [7:0] PwrTarget   = clamp_ticks(POWERUP_TICKS);
    localparam logic [7:0] CmdTarget   = clamp_ticks(CMD_TICKS);
    localparam logic [7:0] ClearTarget = clamp_ticks(CLEAR_TICKS);
    localparam logic [7:0] ETarget     = clamp_ticks(E_TICKS);

    lcd_state_e r_state, w_state_next;
    logic       r_entry;
    logic [1:0] r_idx;
    logic       r_init_done;
    logic       r_rs;
    logic [7:0] r_data;

    logic       w_timed, w_clear, w_enable, w_tick, w_done, w_is_clear;
    logic [7:0] w_target;
    logic       w_load_init, w_accept, w_idx_inc, w_init_set;

    assign w_timed    = (r_state == PWR_WAIT) || (r_state == E_HIGH) || (r_state == E_WAIT);
    // r_entry marks the first cycle in a state; a timed state restarts the timer there.
    assign w_clear    = w_timed && r_entry;
    assign w_enable   = w_timed && !r_entry;
    assign w_tick     = TimerIndicator && w_enable;
    assign w_is_clear = !r_rs && (r_data == CLEAR_CMD);

    always_comb begin
        case (r_state)
            PWR_WAIT: w_target = PwrTarget;
            E_HIGH:   w_target = ETarget;
            E_WAIT:   w_target = w_is_clear ? ClearTarget : CmdTarget;
            default:  w_target = 8'd1;
        endcase
    end

    lcd_tick_counter u_tick_counter (
        .clock    (clock),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_tick   (w_tick),
        .i_target (w_target),
        .o_done   (w_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_load_init  = 1'b0;
        w_accept     = 1'b0;
        w_idx_inc    = 1'b0;
        w_init_set   = 1'b0;
        case (r_state)
            RST_EXIT:  w_state_next = PWR_WAIT;
            PWR_WAIT:  if (w_done) w_state_next = INIT_LOAD;
            INIT_LOAD: begin
                w_load_init  = 1'b1;
                w_state_next = SETUP;
            end
            SETUP:     w_state_next = E_HIGH;
            E_HIGH:    if (w_done) w_state_next = E_WAIT;
            E_WAIT: begin
                if (w_done) begin
                    if (!r_init_done && (r_idx != 2'd3)) begin
                        w_idx_inc    = 1'b1;
                        w_state_next = INIT_LOAD;
                    end else begin
                        w_init_set   = !r_init_done;
                        w_state_next = READY;
                    end
                end
            end
            READY: begin
                if (WrReq) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            default:   w_state_next = RST_EXIT;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state     <= RST_EXIT;
            r_entry     <= 1'b0;
            r_idx       <= 2'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_entry <= (w_state_next != r_state);
            if (w_load_init) begin
                r_rs   <= 1'b0;
                r_data <= init_byte(r_idx);
            end else if (w_accept) begin
                r_rs   <= WrRS;
                r_data <= WrData;
            end
            if (w_idx_inc) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_init_set) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign EnableCount  = w_enable;
    assign DisableCount = w_clear;
    assign WrReady      = (r_state == READY);
    assign InitDone     = r_init_done;
    assign LCD_RS       = r_rs;
    assign LCD_RW       = 1'b0;
    assign LCD_E        = (r_state == E_HIGH);
    assign LCD_DATA     = r_data;

endmodule
